// File: rtl/i2c_regbank_target.sv
// i2c_regbank_target: I2C target with a pointer-addressed register file.
// Burst writes/reads auto-increment the pointer with wrap-around; SDA is driven
// open-drain through sda_oe (1 = pull low).
// Optional macro I2C_RB_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_regbank_target #(
    parameter logic [6:0]  I2C_ADDR = 7'h70,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_strobe_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic                  busy_o
);

    typedef enum logic [3:0] {
        StIdle, StDevAddr, StAckAddr, StRegPtr, StAckPtr,
        StWriteData, StAckWrite, StReadData, StWaitMack
    } state_e;

    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_f, sda_f;
    logic              scl_prev_q, sda_prev_q;
    logic              scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]        byte_in;
    logic              last_bit;

    state_e            state_q;
    logic [7:0]        shift_q;
    logic [3:0]        bit_cnt_q;
    logic              rw_q;
    logic              ack_phase_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        regs_q [NUM_REGS];

    // Two-flop synchronisers; reset to the idle-bus level so no edge is seen at reset
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

`ifdef I2C_RB_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Majority vote over the last three synchronised samples suppresses 1-clk pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
            scl_filt_q <= maj3(scl_hist_q);
            sda_filt_q <= maj3(sda_hist_q);
        end
    end

    assign scl_f = scl_filt_q;
    assign sda_f = sda_filt_q;
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    // Previous-sample registers for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    assign byte_in   = {shift_q[6:0], sda_f};
    assign last_bit  = (bit_cnt_q == 4'd7);

    // Protocol FSM with registered outputs; START/STOP override every state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 4'd0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            ptr_q       <= '0;
            sda_oe      <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            busy_o      <= 1'b0;
            regs_q      <= '{default: 8'h00};
        end else begin
            wr_strobe_o <= 1'b0;
            if (start_det || stop_det) begin
                state_q     <= start_det ? StDevAddr : StIdle;
                bit_cnt_q   <= 4'd0;
                ack_phase_q <= 1'b0;
                sda_oe      <= 1'b0;
                busy_o      <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: ;
                    StDevAddr: if (scl_rise) begin
                        shift_q   <= byte_in;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            bit_cnt_q <= 4'd0;
                            if (byte_in[7:1] == I2C_ADDR) begin
                                rw_q    <= byte_in[0];
                                busy_o  <= 1'b1;
                                state_q <= StAckAddr;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StRegPtr, StWriteData: if (scl_rise) begin
                        shift_q   <= byte_in;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            bit_cnt_q <= 4'd0;
                            if (state_q == StRegPtr) begin
                                ptr_q   <= byte_in[ADDR_W-1:0];
                                state_q <= StAckPtr;
                            end else begin
                                regs_q[ptr_q] <= byte_in;
                                wr_strobe_o   <= 1'b1;
                                wr_addr_o     <= ptr_q;
                                ptr_q         <= ptr_q + ADDR_W'(1);
                                state_q       <= StAckWrite;
                            end
                        end
                    end
                    // First fall drives ACK, second fall ends the ACK clock
                    StAckAddr, StAckPtr, StAckWrite: if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe      <= 1'b1;
                            ack_phase_q <= 1'b1;
                        end else begin
                            ack_phase_q <= 1'b0;
                            sda_oe      <= 1'b0;
                            if (state_q == StAckAddr && rw_q) begin
                                shift_q <= {regs_q[ptr_q][6:0], 1'b0};
                                sda_oe  <= ~regs_q[ptr_q][7];
                                state_q <= StReadData;
                            end else if (state_q == StAckAddr) begin
                                state_q <= StRegPtr;
                            end else begin
                                state_q <= StWriteData;
                            end
                        end
                    end
                    StReadData: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe    <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= StWaitMack;
                            end else begin
                                sda_oe  <= ~shift_q[7];
                                shift_q <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    // ack_phase_q marks a controller ACK waiting for the next fall to reload
                    StWaitMack: begin
                        if (scl_rise && !ack_phase_q) begin
                            if (!sda_f) begin
                                ptr_q       <= ptr_q + ADDR_W'(1);
                                ack_phase_q <= 1'b1;
                            end else begin
                                busy_o  <= 1'b0;
                                state_q <= StIdle;
                            end
                        end else if (scl_fall && ack_phase_q) begin
                            ack_phase_q <= 1'b0;
                            shift_q     <= {regs_q[ptr_q][6:0], 1'b0};
                            sda_oe      <= ~regs_q[ptr_q][7];
                            state_q     <= StReadData;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[8*g +: 8] = regs_q[g];
    end

endmodule

// File: tb/tb_i2c_regbank_target.sv
// tb_i2c_regbank_target: directed I2C controller model with a queue-based scoreboard.
module tb_i2c_regbank_target;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    typedef struct {
        string       name;
        logic [63:0] val;
    } item_t;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_drv = 1'b1;
    logic        sda_drv = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic [63:0] regs_o;
    logic        wr_strobe_o;
    logic [2:0]  wr_addr_o;
    logic        busy_o;

    item_t exp_bus[$];
    item_t obs_bus[$];
    wr_t   exp_wr[$];
    logic [7:0] model [8];
    int    n_tests = 0;
    int    n_fail = 0;
    int    oe_cnt = 0;
    int    oe_snap;
    item_t mon_o, mon_e;
    wr_t   mon_w;

    assign sda_bus = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_regbank_target #(
        .I2C_ADDR(7'h70),
        .NUM_REGS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scl_i(scl_drv),
        .sda_i(sda_bus),
        .sda_oe(sda_oe),
        .regs_o(regs_o),
        .wr_strobe_o(wr_strobe_o),
        .wr_addr_o(wr_addr_o),
        .busy_o(busy_o)
    );

    always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

    // Scoreboard monitor: register writes straight off the DUT, bus items as they appear
    always @(negedge clk) begin
        if (!rst && wr_strobe_o) begin
            n_tests++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %02h, required none",
                         wr_addr_o, regs_o[8*wr_addr_o +: 8]);
            end else begin
                mon_w = exp_wr.pop_front();
                if (wr_addr_o !== mon_w.addr || regs_o[8*mon_w.addr +: 8] !== mon_w.data) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %02h, required addr %0d data %02h",
                             wr_addr_o, regs_o[8*wr_addr_o +: 8], mon_w.addr, mon_w.data);
                end
            end
        end
        while (obs_bus.size() > 0) begin
            mon_o = obs_bus.pop_front();
            n_tests++;
            if (exp_bus.size() == 0) begin
                n_fail++;
                $display("FAIL %s: got %0h, required nothing", mon_o.name, mon_o.val);
            end else begin
                mon_e = exp_bus.pop_front();
                if (mon_o.val !== mon_e.val || mon_o.name != mon_e.name) begin
                    n_fail++;
                    $display("FAIL %s: got %0h, required %0h (%s)",
                             mon_o.name, mon_o.val, mon_e.val, mon_e.name);
                end
            end
        end
    end

    function automatic item_t mk(input string n, input logic [63:0] v);
        item_t it;
        it.name = n;
        it.val  = v;
        return it;
    endfunction

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[8*i +: 8] = model[i];
        return f;
    endfunction

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        exp_bus.push_back(mk(n, exp));
        obs_bus.push_back(mk(n, act));
    endtask

    task automatic expect_write(input logic [2:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
        model[a] = d;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        sda_drv = 1'b0; wait_clks(Q);
        scl_drv = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        sda_drv = 1'b1; wait_clks(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b;    wait_clks(Q);
        scl_drv = 1'b1; wait_clks(2*Q);
        scl_drv = 1'b0; wait_clks(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        b = sda_bus;    wait_clks(Q);
        scl_drv = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        exp_bus.push_back(mk("ack", 64'(exp_ack)));
        read_bit(a);
        obs_bus.push_back(mk("ack", 64'(a)));
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic ack);
        logic [7:0] d;
        logic b;
        exp_bus.push_back(mk("rd_byte", 64'(exp)));
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        obs_bus.push_back(mk("rd_byte", 64'(d)));
        write_bit(ack);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        @(posedge clk); #1;
        wait_clks(4);
        check("rst_sda_oe", 64'(sda_oe), 64'd0);
        check("rst_regs", regs_o, 64'd0);
        check("rst_strobe", 64'(wr_strobe_o), 64'd0);
        check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;
        wait_clks(10);

        // Write burst wrapping past the last register: 6, 7, 0
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h06, 1'b0);
        expect_write(3'd6, 8'hA5); write_byte(8'hA5, 1'b0);
        expect_write(3'd7, 8'h5A); write_byte(8'h5A, 1'b0);
        expect_write(3'd0, 8'hC3); write_byte(8'hC3, 1'b0);
        i2c_stop();
        check("busy_after_stop", 64'(busy_o), 64'd0);

        // Write burst at 2..4
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h02, 1'b0);
        check("busy_active", 64'(busy_o), 64'd1);
        expect_write(3'd2, 8'h11); write_byte(8'h11, 1'b0);
        expect_write(3'd3, 8'h22); write_byte(8'h22, 1'b0);
        expect_write(3'd4, 8'h33); write_byte(8'h33, 1'b0);
        i2c_stop();
        check("regs_after_burst", regs_o, model_flat());

        // Read with repeated START, wrap at 8, NACK on the last byte
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h06, 1'b0);
        i2c_start();
        write_byte(8'hE1, 1'b0);
        read_byte(8'hA5, 1'b0);
        read_byte(8'h5A, 1'b0);
        read_byte(8'hC3, 1'b1);
        check("busy_after_nack", 64'(busy_o), 64'd0);
        i2c_stop();

        // Pointer persists: a bare read starts at the last pointer (0)
        i2c_start();
        write_byte(8'hE1, 1'b0);
        read_byte(8'hC3, 1'b1);
        i2c_stop();

        // Address mismatch: no ACK, no write, SDA never pulled
        oe_snap = oe_cnt;
        i2c_start();
        write_byte(8'hA0, 1'b1);
        write_byte(8'h01, 1'b1);
        write_byte(8'h99, 1'b1);
        i2c_stop();
        check("mismatch_oe_quiet", 64'(oe_cnt - oe_snap), 64'd0);
        check("mismatch_regs", regs_o, model_flat());
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h05, 1'b0);
        expect_write(3'd5, 8'h77); write_byte(8'h77, 1'b0);
        i2c_stop();

        // Aborted byte: 5 data bits then STOP
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h01, 1'b0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        i2c_stop();
        check("abort_regs", regs_o, model_flat());
        check("abort_busy", 64'(busy_o), 64'd0);

        // Reset during the 4th data bit
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h03, 1'b0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        rst = 1'b1;
        wait_clks(1);
        check("midrst_regs", regs_o, 64'd0);
        check("midrst_sda_oe", 64'(sda_oe), 64'd0);
        check("midrst_strobe", 64'(wr_strobe_o), 64'd0);
        check("midrst_wr_addr", 64'(wr_addr_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        scl_drv = 1'b0; wait_clks(Q);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        wait_clks(Q);
        oe_snap = oe_cnt;
        write_byte(8'hE0, 1'b1);
        write_byte(8'h05, 1'b1);
        check("noStart_oe_quiet", 64'(oe_cnt - oe_snap), 64'd0);
        i2c_stop();

        // Fresh transaction after reset, write wrap 7 -> 0, then read back
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h07, 1'b0);
        expect_write(3'd7, 8'h3C); write_byte(8'h3C, 1'b0);
        expect_write(3'd0, 8'h4D); write_byte(8'h4D, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h07, 1'b0);
        i2c_start();
        write_byte(8'hE1, 1'b0);
        read_byte(8'h3C, 1'b0);
        read_byte(8'h4D, 1'b1);
        i2c_stop();
        check("regs_after_reset_txn", regs_o, model_flat());

        // 1-clk SDA low pulse while SCL high in the first data bit of 0xC5
        i2c_start();
        write_byte(8'hE0, 1'b0);
        write_byte(8'h01, 1'b0);
        sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        sda_drv = 1'b0; wait_clks(1);
        sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b0; wait_clks(Q);
`ifdef I2C_RB_GLITCH_FILTER_EN
        expect_write(3'd1, 8'hC5);
        for (int i = 6; i >= 0; i--) write_bit(8'hC5 >> i);
        exp_bus.push_back(mk("glitch_ack", 64'd0));
`else
        for (int i = 6; i >= 0; i--) write_bit(8'hC5 >> i);
        exp_bus.push_back(mk("glitch_ack", 64'd1));
`endif
        begin
            logic a;
            read_bit(a);
            obs_bus.push_back(mk("glitch_ack", 64'(a)));
        end
        i2c_stop();
        check("glitch_regs", regs_o, model_flat());

        wait_clks(4);
        check("writes_outstanding", 64'(exp_wr.size()), 64'd0);
        check("expects_outstanding", 64'(exp_bus.size() - obs_bus.size()), 64'd0);
        wait_clks(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
